axil_cmd_master: RTL and testbench

- AXI4-Lite master that turns a simple command/response stream into single AXI4-Lite read or write transactions, one outstanding at a time.
- Used by control logic, debug bridges and test harnesses to access AXI4-Lite slaves such as the team's register blocks and RAM.
- Pairs with any compliant AXI4-Lite slave, including slaves that return ready only after valid.

---
 rtl/axil_cmd_master.sv | 147 ++++++++++++++
 tb/tb_axil_cmd_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - AXI4-Lite master driven by a command/response stream
// Runs one AXI4-Lite read or write per command, with one transaction outstanding at a time.
module axil_cmd_master #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 16,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    input  logic                  cmd_write,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,

    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,

    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    init_done;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    aw_done;
    logic                    w_done;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    write_q;
    logic                    cmd_fire;
    logic                    aw_fire;
    logic                    w_fire;

    // init_done keeps cmd_ready low while rst is held, without a path from rst to the output
    assign cmd_ready      = (state == IDLE) && init_done;
    assign busy           = (state != IDLE);
    assign rsp_valid      = (state == RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;
    assign rsp_write      = write_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = PROT;
    assign m_axil_awvalid = (state == WR_REQ) && !aw_done;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = (state == WR_REQ) && !w_done;
    assign m_axil_bready  = (state == WR_RESP);
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = PROT;
    assign m_axil_arvalid = (state == RD_REQ);
    assign m_axil_rready  = (state == RD_RESP);

    assign cmd_fire = cmd_valid && cmd_ready;
    assign aw_fire  = m_axil_awvalid && m_axil_awready;
    assign w_fire   = m_axil_wvalid && m_axil_wready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = cmd_write ? WR_REQ : RD_REQ;
            // both beats may complete on the same edge, or either one first
            WR_REQ:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
            WR_RESP: if (m_axil_bvalid) state_next = RESP;
            RD_REQ:  if (m_axil_arready) state_next = RD_RESP;
            RD_RESP: if (m_axil_rvalid) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            init_done <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            write_q   <= 1'b0;
        end else begin
            state     <= state_next;
            init_done <= 1'b1;
            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
            if (state == WR_RESP && m_axil_bvalid) begin
                rdata_q <= '0;
                resp_q  <= m_axil_bresp;
                write_q <= 1'b1;
            end
            if (state == RD_RESP && m_axil_rvalid) begin
                rdata_q <= m_axil_rdata;
                resp_q  <= m_axil_rresp;
                write_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - randomized bench for axil_cmd_master with a memory slave model
// Slave reacts on the falling edge; expected responses come from a byte-strobed memory model.
module tb_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_write = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        busy;
    logic [15:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid;
    logic        m_axil_awready = 1'b0;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready = 1'b0;
    logic [1:0]  m_axil_bresp = 2'b00;
    logic        m_axil_bvalid = 1'b0;
    logic        m_axil_bready;
    logic [15:0] m_axil_araddr;
    logic [2:0]  m_axil_arprot;
    logic        m_axil_arvalid;
    logic        m_axil_arready = 1'b0;
    logic [31:0] m_axil_rdata = '0;
    logic [1:0]  m_axil_rresp = 2'b00;
    logic        m_axil_rvalid = 1'b0;
    logic        m_axil_rready;

    axil_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_write(cmd_write), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .busy(busy),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave configuration, set by the stimulus between transactions
    int         aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0] bresp_sel = 2'b00, rresp_sel = 2'b00;

    logic [31:0] smem [0:63];
    logic [31:0] model [0:63];

    int aw_beats, w_beats, b_beats, ar_beats, r_beats, proto_err;
    int aw_cnt, w_cnt, ar_cnt;
    logic aw_got, w_got;
    logic [15:0] s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        p_awvalid, p_wvalid, p_arvalid, p_bready, p_rready;
    logic [15:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;

    always @(negedge clk) begin
        if (rst) begin
            m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
            m_axil_bvalid = 0; m_axil_rvalid = 0;
            aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            p_awvalid = 0; p_wvalid = 0; p_arvalid = 0; p_bready = 0; p_rready = 0;
        end else begin
            logic aw_f, w_f, ar_f, b_f, r_f;
            aw_f = p_awvalid && m_axil_awready;
            w_f  = p_wvalid && m_axil_wready;
            ar_f = p_arvalid && m_axil_arready;
            b_f  = m_axil_bvalid && p_bready;
            r_f  = m_axil_rvalid && p_rready;
            // a valid must not fall, nor its payload move, until its beat is taken
            if (p_awvalid && !aw_f && (!m_axil_awvalid || m_axil_awaddr !== p_awaddr)) proto_err++;
            if (p_wvalid && !w_f && (!m_axil_wvalid || m_axil_wdata !== p_wdata || m_axil_wstrb !== p_wstrb)) proto_err++;
            if (p_arvalid && !ar_f && (!m_axil_arvalid || m_axil_araddr !== p_araddr)) proto_err++;
            if (aw_f) begin aw_beats++; s_awaddr = p_awaddr; aw_got = 1; aw_cnt = 0; end
            if (w_f) begin w_beats++; s_wdata = p_wdata; s_wstrb = p_wstrb; w_got = 1; w_cnt = 0; end
            if (b_f) begin b_beats++; m_axil_bvalid = 0; end
            if (r_f) begin r_beats++; m_axil_rvalid = 0; end
            if (aw_got && w_got && !m_axil_bvalid) begin
                if (bresp_sel == 2'b00)
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) smem[s_awaddr[7:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
                m_axil_bresp = bresp_sel;
                m_axil_bvalid = 1;
                aw_got = 0; w_got = 0;
            end
            if (ar_f) begin
                ar_beats++;
                m_axil_rdata = smem[p_araddr[7:2]];
                m_axil_rresp = rresp_sel;
                m_axil_rvalid = 1;
                ar_cnt = 0;
            end
            if (m_axil_awvalid) aw_cnt++;
            if (m_axil_wvalid) w_cnt++;
            if (m_axil_arvalid) ar_cnt++;
            m_axil_awready = m_axil_awvalid && (aw_cnt > aw_dly);
            m_axil_wready  = m_axil_wvalid && (w_cnt > w_dly);
            m_axil_arready = m_axil_arvalid && (ar_cnt > ar_dly);
            p_awvalid = m_axil_awvalid; p_wvalid = m_axil_wvalid; p_arvalid = m_axil_arvalid;
            p_bready = m_axil_bready; p_rready = m_axil_rready;
            p_awaddr = m_axil_awaddr; p_araddr = m_axil_araddr;
            p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
        end
    end

    // Issues one command from a falling edge and checks its response against expectations.
    task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, input logic [31:0] exp_rd, input logic [1:0] exp_resp, input int exp_lat);
        int n;
        int lat;
        aw_beats = 0; w_beats = 0; b_beats = 0; ar_beats = 0; r_beats = 0; proto_err = 0;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check("cmd_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        check("rsp_latency", lat, exp_lat);
        check("rsp_fields", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, wr, exp_resp, exp_rd});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_fields", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, wr, exp_resp, exp_rd});
            check("hold_idle_bus", {cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 4'b0000);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("back_to_idle", {cmd_ready, busy, rsp_valid}, 3'b100);
        check("beat_counts", {aw_beats[3:0], w_beats[3:0], b_beats[3:0], ar_beats[3:0], r_beats[3:0]},
              wr ? 20'h11100 : 20'h00011);
        check("valid_protocol", proto_err, 0);
    endtask

    // Reference: expected response and latency from the memory model and slave delays.
    task automatic txn(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        int lat;
        if (wr) begin
            lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
            if (bresp_sel == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[a[7:2]][b*8 +: 8] = d[b*8 +: 8];
            do_cmd(1'b1, a, d, s, hold, 32'h0, bresp_sel, lat);
        end else begin
            lat = 3 + ar_dly;
            do_cmd(1'b0, a, 32'h0, 4'h0, hold, model[a[7:2]], rresp_sel, lat);
        end
    endtask

    task automatic set_slave(input int awd, input int wd, input int ard, input logic [1:0] br, input logic [1:0] rr);
        aw_dly = awd; w_dly = wd; ar_dly = ard; bresp_sel = br; rresp_sel = rr;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin smem[i] = 32'h0; model[i] = 32'h0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd_ready, busy, rsp_valid, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                                m_axil_arvalid, m_axil_rready}, 8'h00);
        check("reset_rsp_regs", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
        check("reset_prot", {m_axil_awprot, m_axil_arprot}, 6'h0);
        rst = 0;
        @(negedge clk);
        check("ready_after_reset", {cmd_ready, busy}, 2'b10);

        set_slave(0, 0, 0, 2'b00, 2'b00);
        txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 16'h0010, 32'h0, 4'h0, 0);
        check("readback_deadbeef", model[4], 32'hDEADBEEF);

        txn(1'b1, 16'h0020, 32'h11223344, 4'hF, 0);
        txn(1'b1, 16'h0020, 32'hAABBCCDD, 4'h3, 0);
        txn(1'b0, 16'h0020, 32'h0, 4'h0, 0);

        set_slave(3, 0, 0, 2'b00, 2'b00);
        txn(1'b1, 16'h0030, 32'h0BADF00D, 4'hF, 0);
        set_slave(0, 3, 0, 2'b00, 2'b00);
        txn(1'b1, 16'h0034, 32'hCAFEF00D, 4'hF, 0);
        set_slave(0, 0, 0, 2'b00, 2'b00);
        txn(1'b0, 16'h0030, 32'h0, 4'h0, 5);
        txn(1'b0, 16'h0034, 32'h0, 4'h0, 0);

        set_slave(0, 0, 0, 2'b10, 2'b11);
        txn(1'b1, 16'h0040, 32'h55555555, 4'hF, 0);
        txn(1'b0, 16'h0010, 32'h0, 4'h0, 0);
        set_slave(0, 0, 0, 2'b00, 2'b00);
        txn(1'b0, 16'h0040, 32'h0, 4'h0, 0);

        // abort a write stuck waiting on awready
        set_slave(50, 50, 0, 2'b00, 2'b00);
        cmd_write = 1; cmd_addr = 16'h0050; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF; cmd_valid = 1;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        check("stuck_in_wr_req", {busy, m_axil_awvalid}, 2'b11);
        rst = 1;
        @(negedge clk);
        check("mid_reset_quiet", {busy, cmd_ready, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                                  m_axil_bready, m_axil_rready, rsp_valid}, 8'h00);
        rst = 0;
        @(negedge clk);
        check("ready_after_abort", cmd_ready, 1'b1);
        set_slave(0, 0, 0, 2'b00, 2'b00);
        txn(1'b0, 16'h0050, 32'h0, 4'h0, 0);
        txn(1'b0, 16'h0020, 32'h0, 4'h0, 0);

        for (int t = 0; t < 150; t++) begin
            logic [1:0] br, rr;
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br, rr);
            txn(1'($urandom_range(0, 1)), {8'h00, 6'($urandom_range(0, 63)), 2'b00},
                $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
